// File: rtl/crc_2_checker_pkg.sv
// Shared definitions for the crc_2 stream checker: state encoding, generator
// taps and the next-bit prediction helper.
package crc_2_checker_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } crc_state_e;

    localparam int HIST_W = 8;

    // History bit k holds stream bit s(n-1-k); taps select s(n-8), s(n-6), s(n-5), s(n-4).
    localparam logic [HIST_W-1:0] CRC2_TAPS = 8'b1011_1000;

    function automatic logic crc2_predict(input logic [HIST_W-1:0] hist);
        return ^(hist & CRC2_TAPS);
    endfunction

endpackage

// File: rtl/crc_2_checker_if.sv
// Serial input and status bundle between a crc_2 stream source and the checker.
interface crc_2_checker_if #(
    parameter int CNT_W = 16
);
    logic             rx_bit;
    logic             rx_valid;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output rx_bit,
        output rx_valid,
        output clear_cnt,
        input  locked,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  rx_bit,
        input  rx_valid,
        input  clear_cnt,
        output locked,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/crc_2_predict.sv
// History shift register with tap-XOR prediction; the shifted-in bit is either
// the received bit or the prediction itself (flywheel).
module crc_2_predict
    import crc_2_checker_pkg::*;
(
    input  logic clock,
    input  logic reset_b,
    input  logic shift_en,
    input  logic use_pred,
    input  logic rx_bit,
    output logic pred,
    output logic next_nonzero
);

    logic [HIST_W-1:0] hist_r;
    logic              pred_s;
    logic              shift_in_s;

    // Prediction from current history and selection of the bit to load.
    always_comb begin
        pred_s     = crc2_predict(hist_r);
        shift_in_s = use_pred ? pred_s : rx_bit;
    end

    // History register, newest bit enters at position 0.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            hist_r <= {HIST_W{1'b0}};
        end else if (shift_en) begin
            hist_r <= {hist_r[HIST_W-2:0], shift_in_s};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign pred         = pred_s;
    assign next_nonzero = ({hist_r[HIST_W-2:0], shift_in_s} != {HIST_W{1'b0}});

endmodule

// File: rtl/crc_2_checker.sv
// Synchronizes to a crc_2 generator bit stream, then flywheels on its own
// prediction, flagging and counting mismatches and dropping lock on error bursts.
module crc_2_checker
    import crc_2_checker_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int WIN        = 64,
    parameter int CNT_W      = 16
) (
    input  logic           clock,
    input  logic           reset_b,
    crc_2_checker_if.slave bus
);

    localparam int FILL_W = $clog2(HIST_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int ERR_W  = $clog2(UNLOCK_ERR + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(HIST_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LEN   = WIN_W'(WIN);
    localparam logic [ERR_W-1:0]  ERR_LIMIT = ERR_W'(UNLOCK_ERR);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    crc_state_e        state_r,    state_nxt_s;
    logic [FILL_W-1:0] fill_cnt_r, fill_cnt_nxt_s;
    logic [GOOD_W-1:0] good_cnt_r, good_cnt_nxt_s;
    logic              win_open_r, win_open_nxt_s;
    logic [WIN_W-1:0]  win_cnt_r,  win_cnt_nxt_s;
    logic [ERR_W-1:0]  win_err_r,  win_err_nxt_s;

    logic              shift_en_s;
    logic              use_pred_s;
    logic              err_hit_s;
    logic              pred_s;
    logic              next_nonzero_s;
    logic              match_s;
    logic              in_win_s;
    logic [ERR_W-1:0]  err_tally_s;

    logic              locked_r;
    logic              err_pulse_r;
    logic [CNT_W-1:0]  err_count_r;

    crc_2_predict u_predict (
        .clock        (clock),
        .reset_b      (reset_b),
        .shift_en     (shift_en_s),
        .use_pred     (use_pred_s),
        .rx_bit       (bus.rx_bit),
        .pred         (pred_s),
        .next_nonzero (next_nonzero_s)
    );

    // Comparison and error-window helpers; a bit at offset WIN from the opening mismatch is outside.
    always_comb begin
        match_s     = (bus.rx_bit == pred_s);
        in_win_s    = win_open_r && (win_cnt_r < WIN_LEN);
        err_tally_s = in_win_s ? (win_err_r + ERR_W'(1)) : ERR_W'(1);
    end

    // Next-state, counter updates and history control.
    always_comb begin
        state_nxt_s    = state_r;
        fill_cnt_nxt_s = fill_cnt_r;
        good_cnt_nxt_s = good_cnt_r;
        win_open_nxt_s = win_open_r;
        win_cnt_nxt_s  = win_cnt_r;
        win_err_nxt_s  = win_err_r;
        shift_en_s     = 1'b0;
        use_pred_s     = 1'b0;
        err_hit_s      = 1'b0;

        if (bus.rx_valid) begin
            shift_en_s = 1'b1;
            case (state_r)
                FILL: begin
                    if (fill_cnt_r == FILL_LAST) begin
                        fill_cnt_nxt_s = {FILL_W{1'b0}};
                        // An all-zero history is the generator lockup state, never a real stream.
                        if (next_nonzero_s) begin
                            state_nxt_s    = VERIFY;
                            good_cnt_nxt_s = {GOOD_W{1'b0}};
                        end else begin
                            state_nxt_s    = FILL;
                        end
                    end else begin
                        fill_cnt_nxt_s = fill_cnt_r + FILL_W'(1);
                    end
                end

                VERIFY: begin
                    if (!match_s) begin
                        good_cnt_nxt_s = {GOOD_W{1'b0}};
                    end else if (good_cnt_r == GOOD_LAST) begin
                        state_nxt_s    = LOCKED;
                        good_cnt_nxt_s = {GOOD_W{1'b0}};
                        win_open_nxt_s = 1'b0;
                        win_cnt_nxt_s  = {WIN_W{1'b0}};
                        win_err_nxt_s  = {ERR_W{1'b0}};
                    end else begin
                        good_cnt_nxt_s = good_cnt_r + GOOD_W'(1);
                    end
                end

                LOCKED: begin
                    use_pred_s = 1'b1;
                    err_hit_s  = !match_s;
                    if (!match_s) begin
                        if (err_tally_s >= ERR_LIMIT) begin
                            state_nxt_s    = FILL;
                            fill_cnt_nxt_s = {FILL_W{1'b0}};
                            win_open_nxt_s = 1'b0;
                            win_cnt_nxt_s  = {WIN_W{1'b0}};
                            win_err_nxt_s  = {ERR_W{1'b0}};
                        end else if (in_win_s) begin
                            win_cnt_nxt_s  = win_cnt_r + WIN_W'(1);
                            win_err_nxt_s  = err_tally_s;
                        end else begin
                            win_open_nxt_s = 1'b1;
                            win_cnt_nxt_s  = WIN_W'(1);
                            win_err_nxt_s  = err_tally_s;
                        end
                    end else if (in_win_s) begin
                        win_cnt_nxt_s  = win_cnt_r + WIN_W'(1);
                    end else begin
                        win_open_nxt_s = 1'b0;
                        win_cnt_nxt_s  = {WIN_W{1'b0}};
                        win_err_nxt_s  = {ERR_W{1'b0}};
                    end
                end

                default: begin
                    state_nxt_s    = FILL;
                    fill_cnt_nxt_s = {FILL_W{1'b0}};
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                end
            endcase
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_r    <= FILL;
            fill_cnt_r <= {FILL_W{1'b0}};
            good_cnt_r <= {GOOD_W{1'b0}};
            win_open_r <= 1'b0;
            win_cnt_r  <= {WIN_W{1'b0}};
            win_err_r  <= {ERR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fill_cnt_r <= fill_cnt_nxt_s;
            good_cnt_r <= good_cnt_nxt_s;
            win_open_r <= win_open_nxt_s;
            win_cnt_r  <= win_cnt_nxt_s;
            win_err_r  <= win_err_nxt_s;
        end
    end

    // Registered status outputs; clear_cnt wins over a plain increment but keeps a coincident error.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
        end else begin
            locked_r    <= (state_nxt_s == LOCKED);
            err_pulse_r <= err_hit_s;
            if (bus.clear_cnt) begin
                err_count_r <= err_hit_s ? CNT_ONE : {CNT_W{1'b0}};
            end else if (err_hit_s && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_ONE;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_crc_2_checker.sv
// Self-checking bench for crc_2_checker: scenario table, hand sequences and
// randomized stimulus against a stream-level reference model.
module tb_crc_2_checker;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_ERR = 4;
    localparam int WIN        = 64;

    logic clock = 1'b0;
    logic reset_b;

    crc_2_checker_if #(.CNT_W(16)) bus16 ();
    crc_2_checker_if #(.CNT_W(4))  bus4 ();

    crc_2_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .WIN(WIN), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus16)
    );

    crc_2_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .WIN(WIN), .CNT_W(4)) dut4 (
        .clock   (clock),
        .reset_b (reset_b),
        .bus     (bus4)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Generator: stream bits obeying s(n)=s(n-8)^s(n-6)^s(n-5)^s(n-4), seeded with 8 bits.
    bit gen_q[$];
    int gen_rd;

    function automatic void gen_seed(input logic [7:0] seed);
        gen_q.delete();
        gen_rd = 0;
        for (int i = 0; i < 8; i++) gen_q.push_back(seed[i]);
    endfunction

    function automatic bit gen_bit();
        int n;
        bit b;
        if (gen_rd >= gen_q.size()) begin
            n = gen_q.size();
            gen_q.push_back(gen_q[n-8] ^ gen_q[n-6] ^ gen_q[n-5] ^ gen_q[n-4]);
        end
        b = gen_q[gen_rd];
        gen_rd++;
        return b;
    endfunction

    // Reference model working on the list of history bits and valid-bit indices.
    bit mh_q[$];
    int m_fill, m_good, m_vidx, m_win_start, m_win_errs, m_count;
    bit m_locked, m_pulse;

    function automatic void model_reset();
        mh_q.delete();
        for (int i = 0; i < 8; i++) mh_q.push_back(1'b0);
        m_fill = 0; m_good = 0; m_vidx = 0; m_win_start = -1; m_win_errs = 0;
        m_count = 0; m_locked = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic bit m_pred();
        int n = mh_q.size();
        return mh_q[n-8] ^ mh_q[n-6] ^ mh_q[n-5] ^ mh_q[n-4];
    endfunction

    function automatic void m_push(input bit b);
        mh_q.push_back(b);
        if (mh_q.size() > 16) void'(mh_q.pop_front());
    endfunction

    function automatic void model_step(input bit b, input bit v, input bit clr);
        bit hit = 1'b0;
        bit p;
        bit any_one;
        if (v) begin
            m_vidx++;
            if (m_locked) begin
                p = m_pred();
                m_push(p);
                if (m_win_start >= 0 && (m_vidx - m_win_start) >= WIN) m_win_start = -1;
                if (b != p) begin
                    hit = 1'b1;
                    if (m_win_start < 0) begin
                        m_win_start = m_vidx;
                        m_win_errs  = 1;
                    end else begin
                        m_win_errs++;
                    end
                    if (m_win_errs >= UNLOCK_ERR) begin
                        m_locked = 1'b0; m_fill = 0; m_win_start = -1;
                    end
                end
            end else if (m_fill < 8) begin
                m_push(b);
                m_fill++;
                if (m_fill == 8) begin
                    any_one = 1'b0;
                    for (int i = 1; i <= 8; i++) any_one |= mh_q[mh_q.size()-i];
                    if (!any_one) m_fill = 0;
                    m_good = 0;
                end
            end else begin
                p = m_pred();
                m_push(b);
                m_good = (b == p) ? m_good + 1 : 0;
                if (m_good == LOCK_CNT) begin
                    m_locked = 1'b1; m_win_start = -1;
                end
            end
        end
        m_pulse = hit;
        if (clr) m_count = hit ? 1 : 0;
        else if (hit && m_count < 65535) m_count++;
    endfunction

    task automatic drive(input bit b, input bit v, input bit c);
        bus16.rx_bit = b; bus16.rx_valid = v; bus16.clear_cnt = c;
        bus4.rx_bit  = b; bus4.rx_valid  = v; bus4.clear_cnt  = c;
    endtask

    task automatic apply(input bit b, input bit v, input bit c);
        drive(b, v, c);
        @(posedge clock);
        #1;
        model_step(b, v, c);
        check("locked",       int'(bus16.locked),    int'(m_locked));
        check("err_pulse",    int'(bus16.err_pulse), int'(m_pulse));
        check("err_count",    int'(bus16.err_count), m_count);
        check("locked_w4",    int'(bus4.locked),     int'(m_locked));
        check("err_count_w4", int'(bus4.err_count),  (m_count > 15) ? 15 : m_count);
    endtask

    task automatic send(input int n, input bit flip_last, input bit clr_last);
        bit b;
        bit last;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            b = gen_bit();
            if (last && flip_last) b = !b;
            apply(b, 1'b1, last && clr_last);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        reset_b = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        check("rst_locked",    int'(bus16.locked),    0);
        check("rst_err_pulse", int'(bus16.err_pulse), 0);
        check("rst_err_count", int'(bus16.err_count), 0);
        @(negedge clock);
        reset_b = 1'b1;
    endtask

    typedef struct {
        int n;
        bit flip;
        bit clr;
        bit exp_locked;
        int exp_cnt;
    } seg_t;

    seg_t segs[$];

    initial begin
        bit seen;
        bit b;
        bit v;
        bit c;
        int vcount;

        segs.push_back('{23,   1'b0, 1'b0, 1'b0, 0});  // FILL + 15 VERIFY
        segs.push_back('{1,    1'b0, 1'b0, 1'b1, 0});  // 24th bit locks
        segs.push_back('{1000, 1'b0, 1'b0, 1'b1, 0});
        segs.push_back('{1,    1'b1, 1'b0, 1'b1, 1});  // single error
        segs.push_back('{100,  1'b0, 1'b0, 1'b1, 1});
        segs.push_back('{1,    1'b0, 1'b1, 1'b1, 0});  // clear without error
        segs.push_back('{1,    1'b1, 1'b0, 1'b1, 1});
        segs.push_back('{10,   1'b1, 1'b0, 1'b1, 2});
        segs.push_back('{10,   1'b1, 1'b0, 1'b1, 3});
        segs.push_back('{10,   1'b1, 1'b0, 1'b0, 4});  // 4th error in window drops lock
        segs.push_back('{23,   1'b0, 1'b0, 1'b0, 4});
        segs.push_back('{1,    1'b0, 1'b0, 1'b1, 4});  // relock after 24 clean bits
        segs.push_back('{1,    1'b1, 1'b1, 1'b1, 1});  // clear coincident with error
        for (int k = 2; k <= 21; k++) segs.push_back('{70, 1'b1, 1'b0, 1'b1, k});

        model_reset();
        drive(1'b0, 1'b0, 1'b0);
        reset_b = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_locked",    int'(bus16.locked),    0);
        check("rst_err_pulse", int'(bus16.err_pulse), 0);
        check("rst_err_count", int'(bus16.err_count), 0);
        check("rst_err_count4", int'(bus4.err_count), 0);
        @(negedge clock);
        reset_b = 1'b1;

        gen_seed(8'h01);
        foreach (segs[i]) begin
            send(segs[i].n, segs[i].flip, segs[i].clr);
            check($sformatf("seg%0d_locked", i), int'(bus16.locked), int'(segs[i].exp_locked));
            check($sformatf("seg%0d_count", i),  int'(bus16.err_count), segs[i].exp_cnt);
            check($sformatf("seg%0d_count4", i), int'(bus4.err_count),
                  (segs[i].exp_cnt > 15) ? 15 : segs[i].exp_cnt);
        end

        // One-cycle pulse, then a gap: nothing moves without rx_valid.
        send(1, 1'b1, 1'b0);
        check("pulse_hi",    int'(bus16.err_pulse), 1);
        check("pulse_cnt",   int'(bus16.err_count), 22);
        apply(1'b1, 1'b0, 1'b0);
        check("pulse_lo",    int'(bus16.err_pulse), 0);
        check("gap_cnt",     int'(bus16.err_count), 22);
        check("gap_locked",  int'(bus16.locked),    1);
        apply(1'b0, 1'b0, 1'b1);
        check("clr_novalid", int'(bus16.err_count), 0);
        send(1, 1'b1, 1'b0);
        check("err_again",   int'(bus16.err_count), 1);
        check("still_lock",  int'(bus16.locked),    1);

        // Asynchronous reset mid-lock clears outputs before the next edge.
        #1;
        reset_b = 1'b0;
        #1;
        check("async_locked",    int'(bus16.locked),    0);
        check("async_err_pulse", int'(bus16.err_pulse), 0);
        check("async_err_count", int'(bus16.err_count), 0);
        model_reset();
        @(negedge clock);
        reset_b = 1'b1;
        gen_seed(8'hA5);
        send(23, 1'b0, 1'b0);
        check("resync_23", int'(bus16.locked), 0);
        send(1, 1'b0, 1'b0);
        check("resync_24", int'(bus16.locked), 1);

        // All-zero input never locks.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            seen |= bus16.locked;
        end
        check("allzero_never_locked", int'(seen), 0);

        // 50% rx_valid duty: lock point counted in valid bits.
        do_reset();
        gen_seed(8'($urandom_range(1, 255)));
        seen = 1'b0;
        vcount = 0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            v = ($urandom_range(0, 1) == 1);
            b = v ? gen_bit() : ($urandom_range(0, 1) == 1);
            apply(b, v, 1'b0);
            if (v) vcount++;
            if (bus16.locked) begin
                seen = 1'b1;
                check("gap_lock_point", vcount, 24);
            end
        end
        if (!seen) check("gap_lock_seen", 0, 1);

        // Randomized traffic with bit errors and occasional clears.
        do_reset();
        gen_seed(8'($urandom_range(1, 255)));
        for (int i = 0; i < 5000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? gen_bit() : ($urandom_range(0, 1) == 1);
            if (v && $urandom_range(0, 39) == 0) b = !b;
            c = ($urandom_range(0, 199) == 0);
            apply(b, v, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_2_checker.md
CRC_2_CHECKER -- requirements
Module: crc_2_checker

Interface
REQ-001 Parameters SHALL be: LOCK_CNT, 16, consecutive correct bits needed to declare lock; UNLOCK_ERR, 4, errors within window forcing loss of lock; WIN, 64, error-window length in valid bits; CNT_W, 16, err_count width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clock, in, 1, rising-edge clock.
- reset_b, in, 1, asynchronous active-low reset.
- rx_bit, in, 1, serial bit from the crc_2 generator (its new polynom[0] each cycle).
- rx_valid, in, 1, qualifies rx_bit; all state holds when low.
- clear_cnt, in, 1, synchronous clear of err_count.
- locked, out, 1, checker synchronized.
- err_pulse, out, 1, one-cycle flag per mismatched bit while LOCKED.
- err_count, out, CNT_W, saturating count of LOCKED mismatches.

Function
REQ-004 The checker SHALL hold an 8-bit history h, with h[k] equal to stream bit s(n-1-k).
REQ-005 The prediction SHALL be p = h[7]^h[5]^h[4]^h[3], matching the generator recurrence s(n)=s(n-8)^s(n-6)^s(n-5)^s(n-4).
REQ-006 Each update SHALL occur only on a clock edge with rx_valid=1; no state, counter or output SHALL change when rx_valid=0.
REQ-007 The state machine SHALL have states FILL, VERIFY and LOCKED.
REQ-008 FILL:
- shift rx_bit into h and count 8 bits.
- after the 8th bit, go to VERIFY if h is nonzero.
- if h is all zero, restart FILL (all-zero lockup is not a valid stream).
REQ-009 VERIFY:
- shift rx_bit into h (self-synchronizing).
- compare rx_bit with p: a match increments good_cnt, a mismatch clears it.
- when good_cnt reaches LOCK_CNT, go to LOCKED.
REQ-010 LOCKED:
- shift p (not rx_bit) into h (flywheel), so bit errors do not corrupt the history.
REQ-011 In LOCKED, a mismatch SHALL, at the next edge:
- assert err_pulse for exactly one cycle.
- increment err_count, saturating at all-ones.
REQ-012 Error window in LOCKED:
- the first mismatch opens a window of WIN valid bits.
- reaching UNLOCK_ERR mismatches inside the window (the first included) SHALL force FILL and drop locked.
- window expiry SHALL clear the window error tally.
REQ-013 locked SHALL be registered:
- it SHALL rise at the edge that enters LOCKED.
- it SHALL fall at the edge that leaves LOCKED.
REQ-014 Latency: err_pulse and locked SHALL follow the qualifying rx_valid edge by exactly one register stage (visible in the following cycle).
REQ-015 clear_cnt handling:
- clear_cnt=1 SHALL zero err_count at the next edge regardless of rx_valid.
- if clear_cnt and a LOCKED error coincide, err_count SHALL become 1.
REQ-016 err_count SHALL NOT change in FILL or VERIFY, and SHALL be preserved across loss of lock.

Reset
REQ-017 On reset_b=0, the block SHALL immediately set:
- h=0, state=FILL, and all internal counters=0.
- locked=0, err_pulse=0, err_count=0.
REQ-018 Reset asserted mid-stream SHALL abandon any lock; after release, resynchronization SHALL restart from FILL.

Structure
REQ-019 A shared package SHALL hold:
- the state enum (FILL, VERIFY, LOCKED).
- the tap constant 8'b1011_1000 (bits 7,5,4,3).
- the history width 8.
REQ-020 The prediction/history shift SHALL be one sub-module, crc_2_predict (history register plus tap XOR, with a load-select between rx_bit and p). FSM and counters SHALL be in crc_2_checker.

Verification
REQ-021 Bench scenarios (drive from a crc_2 generator model, rx_valid=1 unless stated):
- Clean lock: seed 8'h01 -> locked rises after bit 24 (8 FILL + 16 VERIFY); err_count stays 0 for 1000 bits.
- Single error: flip one bit while LOCKED -> err_pulse high 1 cycle, err_count=1, locked stays 1, next 100 bits clean.
- Loss of lock: 4 flips within 64 bits -> locked falls after 4th; relock after 24 further clean bits; err_count=4 retained.
- All-zero input: 200 zero bits -> locked never asserts; state cycles in FILL.
- rx_valid gaps: random rx_valid duty 50% -> same lock point counted in valid bits; no pulses during gaps.
- Counter edges: clear_cnt coincident with error -> err_count=1. With CNT_W=4 and 20 errors -> saturates at 15. reset_b low mid-lock -> all outputs 0 immediately.
